// File: rtl/mc_control_unit_if.sv
// ---------------------------------------------------------------------------
// mc_control_unit_if
// Bundle between the multi-cycle control FSM and the TSC datapath/memory.
//
// Signals
//   opcode, func_code : IR fields from the datapath (valid from ID onward)
//   mem_ready         : memory has completed the current read/write this cycle
//   alu_zero_cond     : branch condition from the datapath (the datapath uses
//                       it to gate pc_write_cond, so the FSM only passes it by)
//   i_or_d .. new_inst: datapath strobes and mux selects driven by the FSM
//
// Handshake: a memory access is requested by mem_read/mem_write (with i_or_d
// selecting the address). The request is held unchanged every cycle until
// the cycle in which mem_ready is 1; that cycle completes the access and the
// FSM moves on at the next clock. mem_ready is ignored while no request is up.
//
// Modports
//   master : the control unit (drives strobes, reads IR fields/mem_ready)
//   slave  : the datapath/memory side
// ---------------------------------------------------------------------------
interface mc_control_unit_if #(
    parameter int OPCODE_W = 4,
    parameter int FUNC_W   = 6
);
    logic [OPCODE_W-1:0] opcode;
    logic [FUNC_W-1:0]   func_code;
    logic                mem_ready;
    logic                alu_zero_cond;

    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                pc_write;
    logic                pc_write_cond;
    logic [1:0]          pc_source;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic                reg_write;
    logic [1:0]          reg_dst;
    logic                mem_to_reg;
    logic                pc_to_reg;
    logic                wwd;
    logic                halt;
    logic                new_inst;

    modport master (
        input  opcode, func_code, mem_ready, alu_zero_cond,
        output i_or_d, mem_read, mem_write, ir_write, pc_write, pc_write_cond,
               pc_source, alu_src_a, alu_src_b, reg_write, reg_dst,
               mem_to_reg, pc_to_reg, wwd, halt, new_inst
    );

    modport slave (
        output opcode, func_code, mem_ready, alu_zero_cond,
        input  i_or_d, mem_read, mem_write, ir_write, pc_write, pc_write_cond,
               pc_source, alu_src_a, alu_src_b, reg_write, reg_dst,
               mem_to_reg, pc_to_reg, wwd, halt, new_inst
    );
endinterface

// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit
// Multi-cycle control FSM for the 16-bit TSC core. Each instruction walks
// through IF, ID, EX, MEM and WB as needed; memory phases stall on mem_ready.
// All strobes are combinational from the current state and the IR fields.
//
// Ports
//   clk      : system clock
//   reset_n  : asynchronous active-low reset (state -> INIT, all strobes 0)
//   bus      : mc_control_unit_if.master (IR fields, mem_ready, strobes)
//   o_state  : current FSM state, for debug/observation
//   num_inst : retired-instruction counter (only with INST_COUNT_EN)
//
// Optional feature macro: INST_COUNT_EN
//   Defined  : adds num_inst[CNT_W-1:0], counting retirements (ID/EX/MEM/WB
//              -> IF transitions), wrapping modulo 2^CNT_W. HLT never counts.
//   Undefined: port and counter absent.
// ---------------------------------------------------------------------------
module mc_control_unit #(
    parameter int OPCODE_W = 4,
    parameter int FUNC_W   = 6,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mc_control_unit_if.master    bus,
    output logic [2:0]           o_state
`ifdef INST_COUNT_EN
    ,
    output logic [CNT_W-1:0]     num_inst
`endif
);
    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_BNE = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_BGZ = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_BLZ = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_ADI = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_ORI = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_LHI = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_LWD = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_SWD = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] OP_JAL = OPCODE_W'(10);
    localparam logic [OPCODE_W-1:0] OP_ALU = OPCODE_W'(15);

    localparam logic [FUNC_W-1:0] FN_JPR = FUNC_W'(25);
    localparam logic [FUNC_W-1:0] FN_JRL = FUNC_W'(26);
    localparam logic [FUNC_W-1:0] FN_WWD = FUNC_W'(28);
    localparam logic [FUNC_W-1:0] FN_HLT = FUNC_W'(29);

    state_t r_state;
    state_t w_next_state;
    logic   r_if_stall;   // previous cycle was an IF cycle without mem_ready
    logic   w_is_branch;
    logic   w_is_alu;
    logic   w_is_lwd;
    logic   w_is_swd;
    logic   w_retire;

    // The zero flag is consumed by the datapath together with pc_write_cond.
    logic   w_unused_zero;
    assign w_unused_zero = bus.alu_zero_cond;

    assign w_is_branch = (bus.opcode == OP_BNE) || (bus.opcode == OP_BEQ) ||
                         (bus.opcode == OP_BGZ) || (bus.opcode == OP_BLZ);
    assign w_is_alu    = (bus.opcode == OP_ALU);
    assign w_is_lwd    = (bus.opcode == OP_LWD);
    assign w_is_swd    = (bus.opcode == OP_SWD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_INIT;
            r_if_stall <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_if_stall <= (r_state == S_IF) && !bus.mem_ready;
        end
    end

    always_comb begin
        w_next_state      = r_state;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_source     = 2'b00;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 2'b00;
        bus.mem_to_reg    = 1'b0;
        bus.pc_to_reg     = 1'b0;
        bus.wwd           = 1'b0;
        bus.halt          = 1'b0;
        bus.new_inst      = 1'b0;

        case (r_state)
            S_INIT: w_next_state = S_IF;

            S_IF: begin
                bus.mem_read = 1'b1;
                bus.new_inst = !r_if_stall;
                if (bus.mem_ready) begin
                    // Fetch completes: latch IR and bump PC by one in the same cycle.
                    bus.ir_write  = 1'b1;
                    bus.pc_write  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    w_next_state  = S_ID;
                end
            end

            S_ID: begin
                // ALU precomputes PC + sign-extended offset for a later branch.
                bus.alu_src_b = 2'b10;
                w_next_state  = S_IF;
                if (bus.opcode == OP_JMP) begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = 2'b10;
                end else if (bus.opcode == OP_JAL) begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = 2'b10;
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 2'b10;
                    bus.pc_to_reg = 1'b1;
                end else if (w_is_alu) begin
                    case (bus.func_code)
                        FN_JPR: begin
                            bus.pc_write  = 1'b1;
                            bus.pc_source = 2'b11;
                        end
                        FN_JRL: begin
                            bus.pc_write  = 1'b1;
                            bus.pc_source = 2'b11;
                            bus.reg_write = 1'b1;
                            bus.reg_dst   = 2'b10;
                            bus.pc_to_reg = 1'b1;
                        end
                        FN_WWD:  bus.wwd     = 1'b1;
                        FN_HLT:  w_next_state = S_HALT;
                        default: w_next_state = S_EX;
                    endcase
                end else if (w_is_branch || w_is_lwd || w_is_swd ||
                             (bus.opcode == OP_ADI) || (bus.opcode == OP_ORI) ||
                             (bus.opcode == OP_LHI)) begin
                    w_next_state = S_EX;
                end
                // Remaining opcodes are undefined and retire as a NOP.
            end

            S_EX: begin
                bus.alu_src_a = 1'b1;
                w_next_state  = S_IF;
                if (w_is_branch) begin
                    bus.alu_src_b     = 2'b00;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = 2'b01;
                end else if (w_is_lwd || w_is_swd) begin
                    bus.alu_src_b = 2'b10;
                    w_next_state  = S_MEM;
                end else if (bus.opcode == OP_ADI) begin
                    bus.alu_src_b = 2'b10;
                    w_next_state  = S_WB;
                end else if ((bus.opcode == OP_ORI) || (bus.opcode == OP_LHI)) begin
                    bus.alu_src_b = 2'b11;
                    w_next_state  = S_WB;
                end else if (w_is_alu) begin
                    bus.alu_src_b = 2'b00;
                    w_next_state  = S_WB;
                end
            end

            S_MEM: begin
                bus.i_or_d    = 1'b1;
                bus.mem_read  = w_is_lwd;
                bus.mem_write = w_is_swd;
                if (bus.mem_ready) begin
                    w_next_state = w_is_lwd ? S_WB : S_IF;
                end
            end

            S_WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = w_is_alu ? 2'b01 : 2'b00;
                bus.mem_to_reg = w_is_lwd;
                w_next_state   = S_IF;
            end

            S_HALT: bus.halt = 1'b1;

            default: w_next_state = S_INIT;
        endcase
    end

    // An instruction retires whenever a non-fetch state hands back to IF.
    assign w_retire = (w_next_state == S_IF) &&
                      ((r_state == S_ID) || (r_state == S_EX) ||
                       (r_state == S_MEM) || (r_state == S_WB));

    assign o_state = r_state;

`ifdef INST_COUNT_EN
    logic [CNT_W-1:0] r_num_inst;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_num_inst <= '0;
        end else if (w_retire) begin
            r_num_inst <= r_num_inst + 1'b1;
        end
    end

    assign num_inst = r_num_inst;
`else
    logic             w_unused_retire;
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_retire = w_retire;
    assign w_unused_cnt    = '0;
`endif

endmodule
